// File: rtl/irq_priority_controller.sv
// Sequenced interrupt controller: sticky pending capture, mask, 8:3 priority pick,
// ack/eoi handshake with optional ack timeout. Define IRQ_EDGE_EN for rising-edge capture.
module irq_priority_controller #(
    parameter int NREQ   = 8,
    parameter int ACK_TO = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [NREQ-1:0] req,
    input  logic            mask_wr,
    input  logic [NREQ-1:0] mask_in,
    input  logic            ack,
    input  logic            eoi,
    output logic            irq,
    output logic [2:0]      irq_id,
    output logic            busy,
    output logic [NREQ-1:0] pending,
    output logic            timeout_err
);
    localparam int TW = (ACK_TO > 0) ? $clog2(ACK_TO + 1) : 1;

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] PEND    = 2'd1;
    localparam logic [1:0] SERVICE = 2'd2;

    logic [1:0]      state;
    logic [NREQ-1:0] mask;
    logic [TW-1:0]   timer;
    logic [NREQ-1:0] set_vec;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] ack_clr;
    logic [2:0]      select;

`ifdef IRQ_EDGE_EN
    logic [NREQ-1:0] req_q;
    logic [NREQ-1:0] req_qq;

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q  <= '0;
            req_qq <= '0;
        end else begin
            req_q  <= req;
            req_qq <= req_q;
        end
    end

    assign set_vec = req_q & ~req_qq;
`else
    assign set_vec = req;
`endif

    assign eligible = pending & ~mask;

    // Ascending scan so the highest set index is the last one written.
    always_comb begin
        select = 3'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (eligible[i]) select = 3'(i);
        end
    end

    assign ack_clr = (state == PEND && ack) ? (NREQ'(1) << irq_id) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            mask        <= '0;
            pending     <= '0;
            timer       <= '0;
            irq         <= 1'b0;
            irq_id      <= 3'd0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            // Set is OR'd after the clear, so a same-cycle request wins over ack.
            pending     <= (pending & ~ack_clr) | set_vec;
            timeout_err <= 1'b0;
            if (mask_wr) mask <= mask_in;
            case (state)
                IDLE: begin
                    if (|eligible) begin
                        state  <= PEND;
                        irq_id <= select;
                        irq    <= 1'b1;
                        timer  <= '0;
                    end
                end
                PEND: begin
                    if (ack) begin
                        irq   <= 1'b0;
                        busy  <= 1'b1;
                        timer <= '0;
                        state <= SERVICE;
                    end else if (ACK_TO != 0 && timer == TW'(ACK_TO - 1)) begin
                        irq         <= 1'b0;
                        timeout_err <= 1'b1;
                        timer       <= '0;
                        state       <= IDLE;
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SERVICE: begin
                    if (eoi) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irq_priority_controller.sv
// Scoreboard bench for irq_priority_controller: expected ids are queued when
// requests are driven and checked when irq is presented.
module tb_irq_priority_controller;
    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic       mask_wr;
    logic [7:0] mask_in;
    logic       ack;
    logic       eoi;
    logic       irq;
    logic [2:0] irq_id;
    logic       busy;
    logic [7:0] pending;
    logic       timeout_err;

    int n_cmp = 0;
    int n_err = 0;
    logic [2:0] exp_q[$];
    logic [2:0] exp_id;

`ifdef IRQ_EDGE_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    irq_priority_controller #(.NREQ(8), .ACK_TO(16)) dut (
        .clk(clk), .rst(rst), .req(req), .mask_wr(mask_wr), .mask_in(mask_in),
        .ack(ack), .eoi(eoi), .irq(irq), .irq_id(irq_id), .busy(busy),
        .pending(pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Bounded wait for irq; expiry counts as a failed comparison.
    task automatic wait_irq(input string name);
        bit ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (irq === 1'b1) begin
                ok = 1'b1;
                break;
            end
            step();
        end
        if (!ok) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s: irq never rose (got %b, want 1)", name, irq);
        end
    endtask

    task automatic ack_eoi();
        ack = 1'b1; step(); ack = 1'b0;
        eoi = 1'b1; step(); eoi = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = '0; mask_wr = 1'b0; mask_in = '0; ack = 1'b0; eoi = 1'b0;
        step(2);
        rst = 1'b0;
        n_cmp++;
        if ({irq, irq_id, busy, pending, timeout_err} !== 14'd0) begin
            n_err++;
            $display("FAIL reset: irq=%b id=%0d busy=%b pend=%h to=%b, want all 0",
                     irq, irq_id, busy, pending, timeout_err);
        end
    endtask

    task automatic test_single();
        req = 8'h01; exp_q.push_back(3'd0);
        step(); req = '0;
        step(LAT);
        n_cmp++;
        if (pending !== 8'h01 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL single_capture: pend=%h irq=%b, want 01 0", pending, irq);
        end
        step();
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_err++;
            $display("FAIL single_latency: irq=%b id=%0d, want 1 %0d", irq, irq_id, exp_id);
        end
        ack = 1'b1; step(); ack = 1'b0;
        n_cmp++;
        if (pending !== 8'h00 || busy !== 1'b1 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL single_ack: pend=%h busy=%b irq=%b, want 00 1 0", pending, busy, irq);
        end
        eoi = 1'b1; step(); eoi = 1'b0;
        step();
        n_cmp++;
        if (busy !== 1'b0 || irq !== 1'b0) begin
            n_err++;
            $display("FAIL single_eoi: busy=%b irq=%b, want 0 0", busy, irq);
        end
    endtask

    task automatic test_priority();
        req = 8'h81; exp_q.push_back(3'd7); exp_q.push_back(3'd0);
        step(); req = '0;
        for (int k = 0; k < 2; k++) begin
            wait_irq("priority");
            exp_id = exp_q.pop_front();
            n_cmp++;
            if (irq_id !== exp_id) begin
                n_err++;
                $display("FAIL priority_%0d: id=%0d, want %0d", k, irq_id, exp_id);
            end
            ack_eoi();
        end
    endtask

    task automatic test_no_preempt();
        req = 8'h04; exp_q.push_back(3'd2);
        step(); req = '0;
        wait_irq("no_preempt");
        req = 8'h40; exp_q.push_back(3'd6);
        step(); req = '0;
        step(3);
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq !== 1'b1 || irq_id !== exp_id) begin
            n_err++;
            $display("FAIL no_preempt_hold: irq=%b id=%0d, want 1 %0d", irq, irq_id, exp_id);
        end
        ack_eoi();
        wait_irq("no_preempt_next");
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq_id !== exp_id) begin
            n_err++;
            $display("FAIL no_preempt_next: id=%0d, want %0d", irq_id, exp_id);
        end
        ack_eoi();
    endtask

    task automatic test_mask();
        mask_in = 8'h80; mask_wr = 1'b1; step(); mask_wr = 1'b0;
        req = 8'h80; step(); req = '0;
        step(4 + LAT);
        n_cmp++;
        if (irq !== 1'b0 || pending !== 8'h80) begin
            n_err++;
            $display("FAIL mask_block: irq=%b pend=%h, want 0 80", irq, pending);
        end
        mask_in = 8'h00; mask_wr = 1'b1; exp_q.push_back(3'd7);
        step(); mask_wr = 1'b0;
        wait_irq("mask_clear");
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq_id !== exp_id) begin
            n_err++;
            $display("FAIL mask_clear: id=%0d, want %0d", irq_id, exp_id);
        end
        ack_eoi();
    endtask

    task automatic test_timeout();
        int cnt = 0;
        req = 8'h08; exp_q.push_back(3'd3); exp_q.push_back(3'd3);
        step(); req = '0;
        wait_irq("timeout");
        while (irq === 1'b1 && cnt < 40) begin
            step();
            cnt++;
        end
        n_cmp++;
        if (cnt !== 16 || timeout_err !== 1'b1 || pending[3] !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_drop: cycles=%0d to=%b pend=%h, want 16 1 bit3",
                     cnt, timeout_err, pending);
        end
        exp_id = exp_q.pop_front();
        step();
        n_cmp++;
        if (irq !== 1'b1 || timeout_err !== 1'b0 || irq_id !== exp_id) begin
            n_err++;
            $display("FAIL timeout_reraise: irq=%b to=%b id=%0d, want 1 0 %0d",
                     irq, timeout_err, irq_id, exp_id);
        end
        exp_id = exp_q.pop_front();
        ack_eoi();
    endtask

    task automatic test_set_wins();
        req = 8'h02; exp_q.push_back(3'd1);
        step();
        wait_irq("set_wins");
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq_id !== exp_id) begin
            n_err++;
            $display("FAIL set_wins_id: id=%0d, want %0d", irq_id, exp_id);
        end
        ack = 1'b1; step(); ack = 1'b0;
        req = '0;
        n_cmp++;
        if (pending !== 8'h02 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL set_wins_pend: pend=%h busy=%b, want 02 1", pending, busy);
        end
`ifdef IRQ_EDGE_EN
        exp_q.push_back(3'd1);
        exp_id = exp_q.pop_front();
`else
        exp_q.push_back(3'd1);
        eoi = 1'b1; step(); eoi = 1'b0;
        wait_irq("set_wins_again");
        exp_id = exp_q.pop_front();
        n_cmp++;
        if (irq_id !== exp_id) begin
            n_err++;
            $display("FAIL set_wins_again: id=%0d, want %0d", irq_id, exp_id);
        end
        ack = 1'b1; step(); ack = 1'b0;
`endif
        eoi = 1'b1; step(); eoi = 1'b0;
        step(2);
    endtask

    task automatic test_rst_mid();
        req = 8'h10; step(); req = 8'h20;
        wait_irq("rst_mid");
        ack = 1'b1; step(); ack = 1'b0; req = '0;
        rst = 1'b1; step(); rst = 1'b0;
        n_cmp++;
        if ({irq, irq_id, busy, pending, timeout_err} !== 14'd0) begin
            n_err++;
            $display("FAIL rst_mid: irq=%b id=%0d busy=%b pend=%h to=%b, want all 0",
                     irq, irq_id, busy, pending, timeout_err);
        end
        step(3);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_quiet: irq=%b, want 0", irq);
        end
`ifdef IRQ_EDGE_EN
        req = 8'h04; step();
        wait_irq("edge_once");
        ack_eoi();
        step(6);
        n_cmp++;
        if (irq !== 1'b0 || pending !== 8'h00) begin
            n_err++;
            $display("FAIL edge_once: irq=%b pend=%h, want 0 00", irq, pending);
        end
        req = '0;
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_priority();
        test_no_preempt();
        test_mask();
        test_timeout();
        test_set_wins();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
